mem_port_arbiter: RTL and testbench

- Shares one single-ported, synchronous-read unified memory between the processor's instruction-fetch port and its data (load/store) port.
- Arbitrates each cycle, issues at most one memory access per cycle, and steers the read response back to its owner one cycle later.
- Returns per-port ready pulses; the pipeline stalls on them.
- Sits between the processor top and the memory model/SRAM.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_grant.sv | 38 +++
 rtl/mem_port_arbiter.sv | 114 +++++++++++
 tb/tb_mem_port_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Also holds the grant encoding used when MEM_ARB_RR_EN selects round-robin.
package mem_arb_pkg;

  // Owner of the access issued in the previous cycle, i.e. whose read
  // response is on mem_rdata in the current cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } resp_owner_e;

  // Which port won the most recent contended cycle.
  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } grant_e;

  // Default data width and the byte-enable width that goes with it.
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_MASK_W = DEF_DATA_W / 8;

endpackage

// File: rtl/mem_port_arbiter_grant.sv
// Issue-stage grant logic: eligibility masking plus the priority choice.
// Fixed data-over-fetch priority by default; with MEM_ARB_RR_EN defined,
// a contended cycle goes to the port that did not win the last contention.
module mem_arb_grant
  import mem_arb_pkg::*;
(
  input  resp_owner_e state,
  input  logic        if_req,
  input  logic        d_req,
`ifdef MEM_ARB_RR_EN
  input  grant_e      last_grant,
  output logic        contention,
`endif
  output logic        grant_i,
  output logic        grant_d
);

  logic   elig_i;
  logic   elig_d;
  grant_e winner;

  // A port is masked in its own response cycle: it is still holding the
  // request it was just served for and must not be issued twice.
  assign elig_i = if_req && (state != RESP_I);
  assign elig_d = d_req  && (state != RESP_D);

`ifdef MEM_ARB_RR_EN
  assign contention = elig_i && elig_d;
  assign winner     = (last_grant == GRANT_D) ? GRANT_I : GRANT_D;
`else
  // The data port belongs to the older instruction, so it wins ties.
  assign winner     = GRANT_D;
`endif

  assign grant_d = elig_d && (!elig_i || (winner == GRANT_D));
  assign grant_i = elig_i && (!elig_d || (winner == GRANT_I));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, 1-cycle-latency memory between the instruction
// fetch port and the load/store port. At most one access issues per cycle;
// the read response is steered to its owner in the following cycle.
// Optional build macro: MEM_ARB_RR_EN (round-robin on contended cycles).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  // instruction fetch port
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_rdata,
  // data port
  input  logic                d_req,
  input  logic                d_wen,
  input  logic [DATA_W/8-1:0] d_wmask,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [DATA_W-1:0]   d_rdata,
  // memory side
  output logic                mem_req,
  output logic                mem_wen,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  resp_owner_e state;
  logic        d_load_q;
  logic        grant_i;
  logic        grant_d;
`ifdef MEM_ARB_RR_EN
  grant_e      last_grant;
  logic        contention;
`endif

  mem_arb_grant u_grant (
    .state      (state),
    .if_req     (if_req),
    .d_req      (d_req),
`ifdef MEM_ARB_RR_EN
    .last_grant (last_grant),
    .contention (contention),
`endif
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

  // Issue mux: drive the memory from whichever port was granted this cycle.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can
    // leave a value held and infer a latch.
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_wmask = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (grant_d) begin
        mem_req   = 1'b1;
        mem_wen   = d_wen;
        mem_wmask = d_wen ? d_wmask : '0;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (grant_i) begin
        mem_req   = 1'b1;
        mem_addr  = if_addr;
      end
    end
  end

  // Response-owner FSM with registered ready pulses and load flag.
  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      state    <= IDLE;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      d_load_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant <= GRANT_D;
`endif
    end else begin
      if (grant_d) begin
        state <= RESP_D;
      end else if (grant_i) begin
        state <= RESP_I;
      end else begin
        state <= IDLE;
      end
      if_ready <= grant_i;
      d_ready  <= grant_d;
      d_load_q <= grant_d && !d_wen;
`ifdef MEM_ARB_RR_EN
      if (contention) begin
        last_grant <= grant_d ? GRANT_D : GRANT_I;
      end
`endif
    end
  end

  // Response steering: read data goes only to its owner, zero otherwise.
  assign if_rdata = if_ready ? mem_rdata : '0;
  assign d_rdata  = (d_ready && d_load_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. Stimulus pushes expected
// responses into per-port queues; a negedge monitor pops and compares them
// whenever a ready pulse appears. Issue-side outputs are checked inline.
module tb_mem_port_arbiter;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        d_req = 1'b0;
  logic        d_wen = 1'b0;
  logic [3:0]  d_wmask = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ready;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_wen;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'hFFFF_FFFF;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t q_i[$];
  exp_t q_d[$];
  bit   lg_i = 1'b0;  // model of the round-robin last grant: 1 = fetch

  mem_port_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_wmask   (d_wmask),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ready   (d_ready),
    .d_rdata   (d_rdata),
    .mem_req   (mem_req),
    .mem_wen   (mem_wen),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory contents seen by reads; a few hand-placed words, a pattern elsewhere.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_2000: return 32'h1122_3344;
      default:       return {a[15:0], 16'hC0DE};
    endcase
  endfunction

  // 1-cycle memory; non-read cycles return junk so leaks are visible.
  always @(posedge clk) begin
    mem_rdata <= (mem_req && !mem_wen) ? rom(mem_addr) : 32'hFFFF_FFFF;
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_i(input logic [31:0] d);
    exp_t e;
    e.due = cyc + 1;
    e.data = d;
    q_i.push_back(e);
  endtask

  task automatic expect_d(input logic [31:0] d);
    exp_t e;
    e.due = cyc + 1;
    e.data = d;
    q_d.push_back(e);
  endtask

  task automatic chk_issue(input string nm, input logic req, input logic wen,
                           input logic [3:0] mask, input logic [31:0] addr,
                           input logic [31:0] wdata);
    check({nm, ".mem_req"},   32'(mem_req),   32'(req));
    check({nm, ".mem_wen"},   32'(mem_wen),   32'(wen));
    check({nm, ".mem_wmask"}, 32'(mem_wmask), 32'(mask));
    if (req) check({nm, ".mem_addr"}, mem_addr, addr);
    if (wen) check({nm, ".mem_wdata"}, mem_wdata, wdata);
  endtask

  task automatic chk_idle(input string nm);
    chk_issue(nm, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  // Both ports request from IDLE in the current cycle.
  task automatic contend(input string nm, input logic [31:0] ia, input logic [31:0] da,
                         input logic dw, input logic [3:0] dm, input logic [31:0] dwd,
                         input logic [31:0] exp_i, input logic [31:0] exp_d);
    bit fetch_first;
    fetch_first = RR && !lg_i;
    lg_i = RR ? fetch_first : 1'b0;
    reset = 1'b1;
    if_req = 1'b1; if_addr = ia;
    d_req = 1'b1; d_wen = dw; d_wmask = dm; d_addr = da; d_wdata = dwd;
    #3;
    if (fetch_first) begin
      chk_issue({nm, ".c0"}, 1'b1, 1'b0, 4'h0, ia, 32'h0); expect_i(exp_i);
    end else begin
      chk_issue({nm, ".c0"}, 1'b1, dw, dw ? dm : 4'h0, da, dwd); expect_d(exp_d);
    end
    next_cycle();
    #3;
    if (fetch_first) begin
      chk_issue({nm, ".c1"}, 1'b1, dw, dw ? dm : 4'h0, da, dwd); expect_d(exp_d);
    end else begin
      chk_issue({nm, ".c1"}, 1'b1, 1'b0, 4'h0, ia, 32'h0); expect_i(exp_i);
    end
    next_cycle();
    if (fetch_first) if_req = 1'b0; else d_req = 1'b0;
    #3 chk_idle({nm, ".c2"});
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    #3 chk_idle({nm, ".c3"});
  endtask

  // One port alone, from IDLE; checks there is no second issue while held.
  task automatic single(input string nm, input bit is_fetch, input logic [31:0] a,
                        input logic w, input logic [3:0] m, input logic [31:0] wd,
                        input logic [31:0] exp);
    if (is_fetch) begin
      if_req = 1'b1; if_addr = a;
    end else begin
      d_req = 1'b1; d_wen = w; d_wmask = m; d_addr = a; d_wdata = wd;
    end
    #3;
    if (is_fetch) begin
      chk_issue({nm, ".c0"}, 1'b1, 1'b0, 4'h0, a, 32'h0); expect_i(exp);
    end else begin
      chk_issue({nm, ".c0"}, 1'b1, w, w ? m : 4'h0, a, wd); expect_d(exp);
    end
    next_cycle();
    #3 chk_idle({nm, ".c1_no_reissue"});
    next_cycle();
    if_req = 1'b0; d_req = 1'b0; d_wen = 1'b0;
    #3 chk_idle({nm, ".c2"});
  endtask

  // Response monitor: pops the per-port queues on ready pulses.
  exp_t e_mon;
  always @(negedge clk) begin
    if (if_ready) begin
      if (q_i.size() == 0) begin
        checks++; failures++;
        $display("FAIL if_ready_unexpected: got if_ready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e_mon = q_i.pop_front();
        check("if_ready_cycle", 32'(cyc), 32'(e_mon.due));
        check("if_rdata", if_rdata, e_mon.data);
      end
    end else begin
      check("if_rdata_idle", if_rdata, 32'h0);
      if (q_i.size() != 0 && q_i[0].due <= cyc) begin
        e_mon = q_i.pop_front();
        check("if_ready_missing", 32'(if_ready), 32'h1);
      end
    end
    if (d_ready) begin
      if (q_d.size() == 0) begin
        checks++; failures++;
        $display("FAIL d_ready_unexpected: got d_ready=1 expected 0 (cycle %0d)", cyc);
      end else begin
        e_mon = q_d.pop_front();
        check("d_ready_cycle", 32'(cyc), 32'(e_mon.due));
        check("d_rdata", d_rdata, e_mon.data);
      end
    end else begin
      check("d_rdata_idle", d_rdata, 32'h0);
      if (q_d.size() != 0 && q_d[0].due <= cyc) begin
        e_mon = q_d.pop_front();
        check("d_ready_missing", 32'(d_ready), 32'h1);
      end
    end
  end

  // Protocol guard: a requester must hold req until its ready pulse.
  bit i_wait = 1'b0;
  bit d_wait = 1'b0;
  always @(negedge clk) begin
    if (reset && i_wait && !if_req) begin
      failures++;
      $display("FAIL if_req_dropped: got if_req=0 expected 1 before if_ready (cycle %0d)", cyc);
    end
    if (reset && d_wait && !d_req) begin
      failures++;
      $display("FAIL d_req_dropped: got d_req=0 expected 1 before d_ready (cycle %0d)", cyc);
    end
    i_wait = reset && if_req && !if_ready;
    d_wait = reset && d_req && !d_ready;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int n_i;
    int n_d;
    bit first_f;
    bit f;
    logic [31:0] a;

    // Reset held with both ports requesting: nothing may issue or complete.
    reset = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h2000;
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #3;
      chk_idle("reset_hold");
      check("reset_hold.if_ready", 32'(if_ready), 32'h0);
      check("reset_hold.d_ready", 32'(d_ready), 32'h0);
    end
    lg_i = 1'b0;

    // Reset released with both pending: first issue in this cycle.
    next_cycle();
    contend("rst_release", 32'h100, 32'h2000, 1'b0, 4'h0, 32'h0,
            32'h0050_0093, 32'h1122_3344);

    // Fetch alone.
    next_cycle();
    single("fetch", 1'b1, 32'h100, 1'b0, 4'h0, 32'h0, 32'h0050_0093);

    // Contention with a load; the load's stray byte enables must not leak.
    next_cycle();
    contend("contend", 32'h104, 32'h2000, 1'b0, 4'hF, 32'h0,
            32'h0104_C0DE, 32'h1122_3344);

    // Store: completes next cycle with zero read data, no double write.
    next_cycle();
    single("store", 1'b0, 32'h2004, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0);

    // Reset asserted across the edge that would capture a fetch response.
    next_cycle();
    if_req = 1'b1; if_addr = 32'h108;
    #3 chk_issue("rst_mid.c0", 1'b1, 1'b0, 4'h0, 32'h108, 32'h0);
    reset = 1'b0;
    lg_i = 1'b0;
    next_cycle();
    #3;
    chk_idle("rst_mid.c1");
    check("rst_mid.if_ready", 32'(if_ready), 32'h0);
    next_cycle();
    reset = 1'b1;
    #3 chk_issue("rst_mid.reissue", 1'b1, 1'b0, 4'h0, 32'h108, 32'h0);
    expect_i(32'h0108_C0DE);
    next_cycle();
    #3 chk_idle("rst_mid.c3");
    next_cycle();
    if_req = 1'b0;
    #3 chk_idle("rst_mid.c4");

    // Both ports requesting continuously for 8 cycles: grants must alternate.
    next_cycle();
    first_f = RR && !lg_i;
    lg_i = RR ? first_f : 1'b0;
    n_i = 0;
    n_d = 0;
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_wen = 1'b0; d_wmask = 4'h0; d_addr = 32'h3000;
    for (int k = 0; k < 8; k++) begin
      f = (k % 2 == 0) ? first_f : !first_f;
      if (f) begin
        a = 32'h200 + 32'(4 * n_i);
        if_addr = a;
        n_i++;
      end else begin
        a = 32'h3000 + 32'(4 * n_d);
        d_addr = a;
        n_d++;
      end
      #3;
      if (f) begin
        chk_issue($sformatf("stream%0d_fetch", k), 1'b1, 1'b0, 4'h0, a, 32'h0);
        expect_i(rom(a));
      end else begin
        chk_issue($sformatf("stream%0d_data", k), 1'b1, 1'b0, 4'h0, a, 32'h0);
        expect_d(rom(a));
      end
      next_cycle();
    end
    if (first_f) if_req = 1'b0; else d_req = 1'b0;
    #3 chk_idle("stream_tail0");
    next_cycle();
    if_req = 1'b0; d_req = 1'b0;
    #3 chk_idle("stream_tail1");
    next_cycle();
    #3 chk_idle("stream_tail2");

    next_cycle();
    next_cycle();
    check("q_i_drained", 32'(q_i.size()), 32'h0);
    check("q_d_drained", 32'(q_d.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
